// File: rtl/irq_controller_if.sv
// irq_controller_if
// Avalon-MM slave bus bundle for the interrupt controller register file.
//   avl_address     : word address of the register (0..7)
//   avl_read        : read request, held by the master until waitrequest drops
//   avl_write       : write request
//   avl_writedata   : write data
//   avl_readdata    : read data, valid when avl_read && !avl_waitrequest
//   avl_waitrequest : stalls the current read for one cycle
// The master modport is used by the bus owner, the slave modport by the controller.
interface irq_controller_if;
    logic [2:0]  avl_address;
    logic        avl_read;
    logic        avl_write;
    logic [31:0] avl_writedata;
    logic [31:0] avl_readdata;
    logic        avl_waitrequest;

    modport master (
        output avl_address,
        output avl_read,
        output avl_write,
        output avl_writedata,
        input  avl_readdata,
        input  avl_waitrequest
    );

    modport slave (
        input  avl_address,
        input  avl_read,
        input  avl_write,
        input  avl_writedata,
        output avl_readdata,
        output avl_waitrequest
    );
endinterface

// File: rtl/irq_controller.sv
// irq_controller
// Aggregates N_SRC interrupt lines into one registered irq for the core.
// Sources are latched (edge or level), masked by ENABLE, and retired through
// CLAIM / COMPLETE registers; source 0 has the highest priority.
// Ports:
//   clk   : single clock
//   rst_n : asynchronous active-low reset
//   src   : raw interrupt lines, synchronous to clk, active-high
//   bus   : Avalon-MM slave (see irq_controller_if)
//   irq   : registered interrupt request to the core
// Register map (word address): 0 STATUS, 1 PENDING (W1C on edge bits),
// 2 ENABLE, 3 TRIGGER (1 = edge), 4 CLAIM, 5 COMPLETE, 6/7 reserved.
module irq_controller #(
    parameter int N_SRC = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_SRC-1:0] src,
    irq_controller_if.slave  bus,
    output logic             irq
);

    localparam logic [0:0] ST_IDLE      = 1'b0;
    localparam logic [0:0] ST_READ_DONE = 1'b1;

    localparam logic [2:0] A_STATUS   = 3'd0;
    localparam logic [2:0] A_PENDING  = 3'd1;
    localparam logic [2:0] A_ENABLE   = 3'd2;
    localparam logic [2:0] A_TRIGGER  = 3'd3;
    localparam logic [2:0] A_CLAIM    = 3'd4;
    localparam logic [2:0] A_COMPLETE = 3'd5;

    logic [0:0]       state_q, state_d;
    logic [2:0]       addr_q, addr_d;
    logic [N_SRC-1:0] pending_q, pending_d;
    logic [N_SRC-1:0] enable_q, enable_d;
    logic [N_SRC-1:0] trigger_q, trigger_d;
    logic [N_SRC-1:0] in_service_q, in_service_d;
    logic [N_SRC-1:0] src_q, src_d;
    logic             irq_q, irq_d;

    logic [N_SRC-1:0] status_s;
    logic [N_SRC-1:0] wdata_s;
    logic [N_SRC-1:0] claim_mask_s;
    logic [N_SRC-1:0] complete_mask_s;
    logic [N_SRC-1:0] w1c_mask_s;
    logic [N_SRC-1:0] edge_next_s;
    logic [31:0]      claim_id_s;
    logic             read_done_s;
    logic             write_en_s;
    logic [31:0]      readdata_s;

    // Returns index+1 of the lowest set bit (highest priority), 0 when empty.
    function automatic logic [31:0] lowest_id(input logic [N_SRC-1:0] v);
        logic [31:0] id;
        id = 32'd0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (v[i]) begin
                id = 32'(i + 1);
            end else begin
                id = id;
            end
        end
        return id;
    endfunction

    // Decode of bus activity and the per-source clear/set masks.
    always_comb begin
        status_s        = pending_q & enable_q & ~in_service_q;
        wdata_s         = bus.avl_writedata[N_SRC-1:0];
        read_done_s     = (state_q == ST_READ_DONE);
        // A read request in the same cycle takes the bus; the write waits.
        write_en_s      = (state_q == ST_IDLE) && bus.avl_write && !bus.avl_read;
        claim_id_s      = lowest_id(status_s);
        claim_mask_s    = {N_SRC{1'b0}};
        complete_mask_s = {N_SRC{1'b0}};
        for (int i = 0; i < N_SRC; i++) begin
            // Claim side effects commit while the CLAIM data is on the bus.
            claim_mask_s[i]    = read_done_s && (addr_q == A_CLAIM) &&
                                 (claim_id_s == 32'(i + 1));
            complete_mask_s[i] = write_en_s && (bus.avl_address == A_COMPLETE) &&
                                 (bus.avl_writedata == 32'(i + 1));
        end
        if (write_en_s && (bus.avl_address == A_PENDING)) begin
            w1c_mask_s = wdata_s;
        end else begin
            w1c_mask_s = {N_SRC{1'b0}};
        end
        // A fresh rising edge wins over a clear in the same cycle.
        edge_next_s = (pending_q & ~(w1c_mask_s | claim_mask_s)) | (src & ~src_q);
    end

    // Next-state logic for the source state vectors and irq.
    always_comb begin
        pending_d    = (trigger_q & edge_next_s) | (~trigger_q & src);
        src_d        = src;
        in_service_d = (in_service_q | claim_mask_s) & ~complete_mask_s;
        irq_d        = |status_s;
        if (write_en_s && (bus.avl_address == A_ENABLE)) begin
            enable_d = wdata_s;
        end else begin
            enable_d = enable_q;
        end
        if (write_en_s && (bus.avl_address == A_TRIGGER)) begin
            trigger_d = wdata_s;
        end else begin
            trigger_d = trigger_q;
        end
    end

    // Read FSM: one stall cycle, then data in READ_DONE.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.avl_read) begin
                    state_d = ST_READ_DONE;
                    addr_d  = bus.avl_address;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Read data mux, driven only in the READ_DONE cycle.
    always_comb begin
        readdata_s = 32'd0;
        if (read_done_s) begin
            case (addr_q)
                A_STATUS:  readdata_s = 32'(status_s);
                A_PENDING: readdata_s = 32'(pending_q);
                A_ENABLE:  readdata_s = 32'(enable_q);
                A_TRIGGER: readdata_s = 32'(trigger_q);
                A_CLAIM:   readdata_s = claim_id_s;
                default:   readdata_s = 32'd0;
            endcase
        end else begin
            readdata_s = 32'd0;
        end
    end

    // State registers; reset mid-read drops the read with no side effects.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            addr_q       <= 3'd0;
            pending_q    <= {N_SRC{1'b0}};
            enable_q     <= {N_SRC{1'b0}};
            trigger_q    <= {N_SRC{1'b0}};
            in_service_q <= {N_SRC{1'b0}};
            src_q        <= {N_SRC{1'b0}};
            irq_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            pending_q    <= pending_d;
            enable_q     <= enable_d;
            trigger_q    <= trigger_d;
            in_service_q <= in_service_d;
            src_q        <= src_d;
            irq_q        <= irq_d;
        end
    end

    assign bus.avl_readdata    = readdata_s;
    assign bus.avl_waitrequest = (state_q == ST_IDLE) && bus.avl_read;
    assign irq                 = irq_q;

endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller
// Directed test-plan steps followed by a randomized phase, all checked against
// a per-source behavioural model of the register rules kept in this bench.
module tb_irq_controller;
    localparam int N = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] src_r;
    logic         irq;

    irq_controller_if bus_if ();

    irq_controller #(.N_SRC(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .src   (src_r),
        .bus   (bus_if),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: one flag per source and per property.
    bit m_pend [N];
    bit m_en   [N];
    bit m_trig [N];
    bit m_ins  [N];
    bit m_prev [N];
    bit m_irq;
    bit m_rd;
    int m_addr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_claim();
        for (int i = 0; i < N; i++) begin
            if (m_pend[i] && m_en[i] && !m_ins[i]) return i + 1;
        end
        return 0;
    endfunction

    function automatic logic [31:0] model_read();
        logic [31:0] v;
        v = 32'd0;
        for (int i = 0; i < N; i++) begin
            case (m_addr)
                0: v[i] = m_pend[i] && m_en[i] && !m_ins[i];
                1: v[i] = m_pend[i];
                2: v[i] = m_en[i];
                3: v[i] = m_trig[i];
                default: v[i] = 1'b0;
            endcase
        end
        if (m_addr == 4) v = 32'(model_claim());
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_pend[i] = 1'b0; m_en[i] = 1'b0; m_trig[i] = 1'b0;
            m_ins[i] = 1'b0;  m_prev[i] = 1'b0;
        end
        m_irq = 1'b0; m_rd = 1'b0; m_addr = 0;
    endtask

    // Advance the model by one clock using the inputs as they stand, then
    // step the DUT and compare irq.
    task automatic tick();
        bit wr_ok, clr, nirq;
        int cid, wa;
        wr_ok = !m_rd && bus_if.avl_write && !bus_if.avl_read;
        wa    = int'(bus_if.avl_address);
        cid   = (m_rd && m_addr == 4) ? model_claim() : 0;
        nirq  = 1'b0;
        for (int i = 0; i < N; i++) nirq |= m_pend[i] && m_en[i] && !m_ins[i];
        for (int i = 0; i < N; i++) begin
            clr = (wr_ok && wa == 1 && bus_if.avl_writedata[i]) || (cid == i + 1);
            if (m_trig[i]) m_pend[i] = (m_pend[i] && !clr) || (src_r[i] && !m_prev[i]);
            else           m_pend[i] = src_r[i];
            m_prev[i] = src_r[i];
            if (wr_ok && wa == 2) m_en[i]   = bus_if.avl_writedata[i];
            if (wr_ok && wa == 3) m_trig[i] = bus_if.avl_writedata[i];
            if (cid == i + 1) m_ins[i] = 1'b1;
            if (wr_ok && wa == 5 && bus_if.avl_writedata == 32'(i + 1)) m_ins[i] = 1'b0;
        end
        m_irq = nirq;
        if (m_rd) m_rd = 1'b0;
        else if (bus_if.avl_read) begin
            m_rd = 1'b1;
            m_addr = wa;
        end
        @(posedge clk);
        #1;
        chk("irq", {31'd0, irq}, {31'd0, m_irq});
    endtask

    task automatic do_write(input int addr, input logic [31:0] data);
        bus_if.avl_address   = 3'(addr);
        bus_if.avl_writedata = data;
        bus_if.avl_write     = 1'b1;
        tick();
        bus_if.avl_write     = 1'b0;
    endtask

    task automatic do_read(input int addr, output logic [31:0] data);
        bus_if.avl_address = 3'(addr);
        bus_if.avl_read    = 1'b1;
        #1;
        chk("waitreq_stall", {31'd0, bus_if.avl_waitrequest}, 32'd1);
        tick();
        chk("waitreq_done", {31'd0, bus_if.avl_waitrequest}, 32'd0);
        chk($sformatf("rdata_a%0d", addr), bus_if.avl_readdata, model_read());
        data = bus_if.avl_readdata;
        bus_if.avl_read = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus_if.avl_read  = 1'b0;
        bus_if.avl_write = 1'b0;
        model_reset();
        #1;
        chk("rst_irq", {31'd0, irq}, 32'd0);
        chk("rst_waitreq", {31'd0, bus_if.avl_waitrequest}, 32'd0);
        chk("rst_rdata", bus_if.avl_readdata, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] d;
        int op;
        rst_n = 1'b0;
        src_r = '0;
        bus_if.avl_address = 3'd0;
        bus_if.avl_read = 1'b0;
        bus_if.avl_write = 1'b0;
        bus_if.avl_writedata = 32'd0;
        @(posedge clk);
        #1;
        do_reset();
        for (int a = 0; a < 4; a++) begin
            do_read(a, d);
            chk("reset_reg", d, 32'd0);
        end

        // Edge source 2: irq two cycles after the pulse, claim, complete.
        do_write(3, 32'h4);
        do_write(2, 32'h4);
        src_r[2] = 1'b1; tick();
        src_r[2] = 1'b0; tick();
        chk("edge_irq_up", {31'd0, irq}, 32'd1);
        do_read(4, d);
        chk("edge_claim", d, 32'd3);
        tick();
        chk("edge_irq_down", {31'd0, irq}, 32'd0);
        do_write(5, 32'd3);
        tick(); tick();
        chk("edge_after_complete", {31'd0, irq}, 32'd0);

        // Priority between sources 5 and 9.
        do_reset();
        do_write(3, 32'h220);
        do_write(2, 32'h220);
        src_r = 16'h0220; tick();
        src_r = 16'h0000; tick(); tick();
        do_read(4, d); chk("prio_first", d, 32'd6);
        do_read(4, d); chk("prio_second", d, 32'd10);
        do_read(4, d); chk("prio_empty", d, 32'd0);
        do_read(0, d); chk("prio_status", d, 32'd0);

        // Level source 0.
        do_reset();
        do_write(2, 32'h1);
        src_r[0] = 1'b1; tick(); tick();
        chk("lvl_irq_up", {31'd0, irq}, 32'd1);
        do_read(4, d); chk("lvl_claim", d, 32'd1);
        tick();
        chk("lvl_irq_down", {31'd0, irq}, 32'd0);
        do_write(5, 32'd1);
        tick();
        chk("lvl_reassert", {31'd0, irq}, 32'd1);
        src_r[0] = 1'b0; tick();
        do_read(1, d); chk("lvl_pend_clear", d & 32'h1, 32'd0);

        // New edge wins over a same-cycle W1C.
        do_reset();
        do_write(3, 32'h2);
        src_r[1] = 1'b1; tick();
        src_r[1] = 1'b0; tick();
        src_r[1] = 1'b1;
        do_write(1, 32'h2);
        do_read(1, d); chk("set_dominates", d, 32'h2);
        src_r[1] = 1'b0;

        // Masked source and W1C.
        do_reset();
        do_write(3, 32'h10);
        src_r[4] = 1'b1; tick();
        src_r[4] = 1'b0; tick(); tick();
        chk("mask_irq", {31'd0, irq}, 32'd0);
        do_read(0, d); chk("mask_status", d, 32'd0);
        do_read(1, d); chk("mask_pending", d, 32'h10);
        do_write(1, 32'h10);
        do_read(1, d); chk("w1c_pending", d, 32'd0);

        // Reset during READ_DONE of a CLAIM.
        do_reset();
        do_write(2, 32'h8);
        src_r[3] = 1'b1; tick(); tick();
        chk("rst_pre_irq", {31'd0, irq}, 32'd1);
        bus_if.avl_address = 3'd4;
        bus_if.avl_read = 1'b1;
        tick();
        do_reset();
        do_write(3, 32'h8);
        do_read(1, d); chk("rst_src3_pending", d, 32'h8);
        src_r = '0;

        // Randomized traffic.
        do_reset();
        do_write(3, $urandom);
        do_write(2, $urandom);
        for (int it = 0; it < 400; it++) begin
            src_r = src_r ^ (16'($urandom) & 16'($urandom));
            op = $urandom_range(0, 9);
            case (op)
                0, 1, 2: tick();
                3: do_write($urandom_range(0, 7), $urandom);
                4: do_write(1, $urandom);
                5: do_write(5, 32'($urandom_range(0, 18)));
                6, 7: do_read(4, d);
                8: do_read($urandom_range(0, 7), d);
                default: begin
                    bus_if.avl_address   = 3'($urandom_range(0, 7));
                    bus_if.avl_writedata = $urandom;
                    bus_if.avl_write     = 1'b1;
                    bus_if.avl_read      = 1'b1;
                    #1;
                    chk("rw_stall", {31'd0, bus_if.avl_waitrequest}, 32'd1);
                    tick();
                    chk("rw_rdata", bus_if.avl_readdata, model_read());
                    bus_if.avl_write = 1'b0;
                    bus_if.avl_read  = 1'b0;
                    tick();
                end
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
